// File: rtl/cp0_regs_pkg.sv
// Shared CP0 definitions: scalar types, register indices, ExcCode values,
// the exception vector and the reset/write-mask constants of Status.
package cp0_regs_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [4:0]  i5;

  localparam i5 CP0_BADVADDR = 5'd8;
  localparam i5 CP0_COUNT    = 5'd9;
  localparam i5 CP0_COMPARE  = 5'd11;
  localparam i5 CP0_STATUS   = 5'd12;
  localparam i5 CP0_CAUSE    = 5'd13;
  localparam i5 CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } exc_code_e;

  localparam addr_t EXC_VECTOR   = 32'hBFC0_0380;
  localparam word_t STATUS_RESET = 32'h0040_0000;
  // IM[15:8], EXL[1], IE[0]; BEV stays at its reset value forever.
  localparam word_t STATUS_WMASK = 32'h0000_FF03;

  function automatic logic is_addr_exc(input i5 code);
    return (code == i5'(EXC_ADEL)) || (code == i5'(EXC_ADES));
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair and the timer-interrupt flag.
// Count advances every second cycle; an MTC0 to Count replaces that cycle's step.
module cp0_timer
  import cp0_regs_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  count_wen_i,
  input  logic  compare_wen_i,
  input  word_t wdata_i,
  output word_t count_o,
  output word_t compare_o,
  output logic  ti_o
);

  word_t count_q, count_d;
  word_t compare_q, compare_d;
  logic  toggle_q, toggle_d;
  logic  ti_q, ti_d;

  always_comb begin
    toggle_d  = ~toggle_q;
    count_d   = count_q + {31'd0, toggle_q};
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_wen_i) count_d = wdata_i;
    if (count_q == compare_q) ti_d = 1'b1;
    // A clear from a Compare write wins over a coincident match.
    if (compare_wen_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      toggle_q  <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      toggle_q  <= toggle_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: exception/ERET entry and exit, MTC0/MFC0 access and
// interrupt request generation. Redirect and read paths are combinational.
module cp0_regs
  import cp0_regs_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       exc_valid,
  input  i5          exc_code,
  input  addr_t      exc_badvaddr,
  input  addr_t      exc_pc,
  input  logic       exc_in_ds,
  input  logic       eret,
  input  logic       wen,
  input  logic [4:0] waddr,
  input  word_t      wdata,
  input  logic [4:0] raddr,
  output word_t      rdata,
  input  logic [5:0] ext_int,
  output logic       int_req,
  output logic       redirect_valid,
  output addr_t      redirect_pc
);

  word_t      status_q, status_d;
  addr_t      epc_q, epc_d;
  addr_t      badvaddr_q, badvaddr_d;
  logic       bd_q, bd_d;
  i5          exccode_q, exccode_d;
  logic [1:0] ip_sw_q, ip_sw_d;
  logic [5:0] ip_hw_q, ip_hw_d;

  word_t count, compare, cause;
  logic  ti;
  logic  do_eret, do_wr;

  // Lower-priority events are discarded, not deferred.
  assign do_eret = eret & ~exc_valid;
  assign do_wr   = wen & ~exc_valid & ~eret;

  cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .count_wen_i  (do_wr && (waddr == CP0_COUNT)),
    .compare_wen_i(do_wr && (waddr == CP0_COMPARE)),
    .wdata_i      (wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  assign cause = {bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = {ext_int[5] | ti, ext_int[4:0]};
    if (exc_valid) begin
      status_d[1] = 1'b1;
      exccode_d   = exc_code;
      if (!status_q[1]) begin
        epc_d = exc_in_ds ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_in_ds;
      end
      if (is_addr_exc(exc_code)) badvaddr_d = exc_badvaddr;
    end else if (do_eret) begin
      status_d[1] = 1'b0;
    end else if (do_wr) begin
      case (waddr)
        CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
        CP0_CAUSE:  ip_sw_d  = wdata[9:8];
        CP0_EPC:    epc_d    = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= STATUS_RESET;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_BADVADDR: rdata = badvaddr_q;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status_q;
      CP0_CAUSE:    rdata = cause;
      CP0_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

  assign int_req = ~reset & status_q[0] & ~status_q[1]
                 & (|({ip_hw_q, ip_sw_q} & status_q[15:8]));
  assign redirect_valid = ~reset & (exc_valid | eret);
  assign redirect_pc    = exc_valid ? EXC_VECTOR : epc_q;

endmodule

// File: tb/tb_cp0_regs.sv
// Directed test of cp0_regs: exceptions, ERET, write masks, priority,
// timer interrupt and reset behaviour.
module tb_cp0_regs;
  logic        clk = 1'b0;
  logic        reset, exc_valid, exc_in_ds, eret, wen;
  logic [4:0]  exc_code, waddr, raddr;
  logic [31:0] exc_badvaddr, exc_pc, wdata, rdata, redirect_pc, v;
  logic [5:0]  ext_int;
  logic        int_req, redirect_valid;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cp0_regs dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_badvaddr(exc_badvaddr), .exc_pc(exc_pc), .exc_in_ds(exc_in_ds),
    .eret(eret), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata), .ext_int(ext_int), .int_req(int_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exc_valid = 0; exc_code = 0; exc_badvaddr = 0; exc_pc = 0; exc_in_ds = 0;
    eret = 0; wen = 0; waddr = 0; wdata = 0; ext_int = 0; reset = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    raddr = a;
    #1;
    d = rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wen = 1; waddr = a; wdata = d;
    tick();
    wen = 0;
  endtask

  task automatic raise(input logic [4:0] code, input logic [31:0] bad,
                       input logic [31:0] pc, input logic ds);
    exc_valid = 1; exc_code = code; exc_badvaddr = bad; exc_pc = pc; exc_in_ds = ds;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0380) begin
      errors++;
      $display("FAIL exc_redirect: got %b/%h expected 1/bfc00380", redirect_valid, redirect_pc);
    end
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1; exc_valid = 1; exc_code = 5'h5; eret = 1; wen = 1; waddr = 14; wdata = 32'hFFFF;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b ir=%b expected 0/0", redirect_valid, int_req);
    end
    tick();
    idle();
    rd(12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL reset_status: got %h expected 00400000", v); end
    rd(9, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", v); end
    rd(13, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h expected 0", v); end
    rd(14, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected 0", v); end
    rd(8, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_badvaddr: got %h expected 0", v); end
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $display("FAIL idle_redirect: got %b expected 0", redirect_valid); end
  endtask

  task automatic test_ades();
    raise(5'h5, 32'h8000_0002, 32'hBFC0_0100, 1'b0);
    rd(14, v); checks++;
    if (v !== 32'hBFC0_0100) begin errors++; $display("FAIL ades_epc: got %h expected bfc00100", v); end
    rd(8, v); checks++;
    if (v !== 32'h8000_0002) begin errors++; $display("FAIL ades_badvaddr: got %h expected 80000002", v); end
    rd(13, v); checks++;
    if (v[6:2] !== 5'h5 || v[31] !== 1'b0) begin errors++; $display("FAIL ades_cause: got %h expected code 5 bd 0", v); end
    rd(12, v); checks++;
    if (v !== 32'h0040_0002) begin errors++; $display("FAIL ades_status: got %h expected 00400002", v); end
    eret = 1; #1; checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0100) begin
      errors++; $display("FAIL ades_eret: got %b/%h expected 1/bfc00100", redirect_valid, redirect_pc);
    end
    tick(); idle();
    rd(12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL ades_eret_exl: got %h expected 00400000", v); end
  endtask

  task automatic test_ds_ov();
    raise(5'hc, 32'hDEAD_BEEF, 32'hBFC0_0204, 1'b1);
    rd(14, v); checks++;
    if (v !== 32'hBFC0_0200) begin errors++; $display("FAIL ds_epc: got %h expected bfc00200", v); end
    rd(13, v); checks++;
    if (v[31] !== 1'b1 || v[6:2] !== 5'hc) begin errors++; $display("FAIL ds_cause: got %h expected bd 1 code c", v); end
    rd(8, v); checks++;
    if (v !== 32'h8000_0002) begin errors++; $display("FAIL ds_badvaddr: got %h expected 80000002", v); end
    eret = 1; #1; checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0200) begin
      errors++; $display("FAIL ds_eret: got %b/%h expected 1/bfc00200", redirect_valid, redirect_pc);
    end
    tick(); idle();
    rd(12, v); checks++;
    if (v[1] !== 1'b0) begin errors++; $display("FAIL ds_eret_exl: got %h expected exl 0", v); end
  endtask

  task automatic test_nested();
    raise(5'h8, 32'h0, 32'h0000_1000, 1'b0);
    raise(5'ha, 32'h0, 32'h0000_1234, 1'b1);
    rd(14, v); checks++;
    if (v !== 32'h0000_1000) begin errors++; $display("FAIL nested_epc: got %h expected 00001000", v); end
    rd(13, v); checks++;
    if (v[6:2] !== 5'ha || v[31] !== 1'b0) begin errors++; $display("FAIL nested_cause: got %h expected code a bd 0", v); end
    eret = 1; tick(); idle();
  endtask

  task automatic test_priority();
    eret = 1; wen = 1; waddr = 14; wdata = 32'h5555_5555;
    raise(5'h9, 32'h0, 32'h0000_2000, 1'b0);
    rd(14, v); checks++;
    if (v !== 32'h0000_2000) begin errors++; $display("FAIL prio_epc: got %h expected 00002000", v); end
    rd(12, v); checks++;
    if (v !== 32'h0040_0002) begin errors++; $display("FAIL prio_status: got %h expected 00400002", v); end
    eret = 1; wen = 1; waddr = 12; wdata = 32'h0000_0001;
    tick(); idle();
    rd(12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL prio_eret_wen: got %h expected 00400000", v); end
  endtask

  task automatic test_masks();
    mtc0(12, 32'hFFFF_FFFF);
    rd(12, v); checks++;
    if (v !== 32'h0040_FF03) begin errors++; $display("FAIL mask_status: got %h expected 0040ff03", v); end
    mtc0(12, 32'h0);
    rd(12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL mask_bev: got %h expected 00400000", v); end
    mtc0(13, 32'hFFFF_FFFF);
    rd(13, v); checks++;
    if ((v & 32'h8000_03FF) !== 32'h0000_0324) begin errors++; $display("FAIL mask_cause: got %h expected sw/code field 324", v); end
    mtc0(8, 32'h0000_0001);
    rd(8, v); checks++;
    if (v !== 32'h8000_0002) begin errors++; $display("FAIL mask_badvaddr: got %h expected 80000002", v); end
    mtc0(14, 32'hCAFE_BABE);
    rd(14, v); checks++;
    if (v !== 32'hCAFE_BABE) begin errors++; $display("FAIL mask_epc: got %h expected cafebabe", v); end
    mtc0(3, 32'h1234_5678);
    rd(3, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mask_unimpl: got %h expected 0", v); end
    mtc0(13, 32'h0);
  endtask

  task automatic test_ext_int();
    mtc0(12, 32'h0000_0401);
    ext_int = 6'b000001;
    tick(); #1; checks++;
    if (int_req !== 1'b1) begin errors++; $display("FAIL extint_on: got %b expected 1", int_req); end
    ext_int = 6'b0;
    tick(); #1; checks++;
    if (int_req !== 1'b0) begin errors++; $display("FAIL extint_off: got %b expected 0", int_req); end
    mtc0(12, 32'h0);
  endtask

  task automatic test_timer();
    reset = 1; tick(); idle();
    mtc0(11, 32'd5);
    mtc0(12, 32'h0000_8001);
    repeat (8) tick();
    rd(9, v); checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL timer_count5: got %0d expected 5", v); end
    rd(13, v); checks++;
    if (v[30] !== 1'b0 || int_req !== 1'b0) begin errors++; $display("FAIL timer_early: got ti=%b ir=%b expected 0/0", v[30], int_req); end
    tick();
    rd(13, v); checks++;
    if (v[30] !== 1'b1) begin errors++; $display("FAIL timer_ti: got %b expected 1", v[30]); end
    tick(); #1; checks++;
    if (int_req !== 1'b1) begin errors++; $display("FAIL timer_intreq: got %b expected 1", int_req); end
    mtc0(11, 32'd100);
    rd(13, v); checks++;
    if (v[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_clr: got %b expected 0", v[30]); end
    tick(); #1; checks++;
    if (int_req !== 1'b0) begin errors++; $display("FAIL timer_intreq_clr: got %b expected 0", int_req); end
    tick();
    mtc0(9, 32'hFFFF_FFFF);
    rd(9, v); checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_load: got %h expected ffffffff", v); end
    tick(); tick();
    rd(9, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL timer_wrap: got %h expected 0", v); end
  endtask

  task automatic test_reset_mid();
    mtc0(9, 32'd100);
    raise(5'h8, 32'h0, 32'h0000_3000, 1'b0);
    reset = 1; exc_valid = 1; #1; checks++;
    if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rstmid_redirect: got %b expected 0", redirect_valid); end
    tick(); idle();
    rd(12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL rstmid_status: got %h expected 00400000", v); end
    rd(9, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rstmid_count: got %h expected 0", v); end
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rv: got %b expected 0", redirect_valid); end
  endtask

  initial begin
    idle();
    raddr = 0;
    reset = 1;
    tick(); tick();
    test_reset();
    test_ades();
    test_ds_ov();
    test_nested();
    test_priority();
    test_masks();
    test_ext_int();
    test_timer();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
